fetch_queue: RTL and testbench

- Instruction prefetch buffer between the program counter/instruction memory and the decoder of the 8-bit micro-processor.
- Drives the instruction-memory read address, captures 16-bit instructions into a small FIFO tagged with their PC, and hands them to decode with a valid/ready handshake.
- Flushes and restarts on control-flow redirects: taken conditional jump or stack return.

---
 rtl/fetch_queue.sv | 84 ++++++++
 tb/tb_fetch_queue.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between imem and decode, flushed on redirect.
// Define FETCHQ_BYPASS_EN to let an empty queue forward imem_data straight to decode.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect,
  input  logic [AW-1:0]          redirect_pc,
  output logic [AW-1:0]          imem_addr,
  input  logic [IW-1:0]          imem_data,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [IW-1:0]          dec_inst,
  output logic [AW-1:0]          dec_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] fetch_pc, last_pc;
  logic [IW-1:0] last_inst;
  logic [AW-1:0] pc_mem [DEPTH];
  logic [IW-1:0] inst_mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic filled, full, pop, push, wr;
  assign imem_addr = fetch_pc;
  assign filled = count != '0;
  assign full = count == CW'(DEPTH);
  assign pop = filled & dec_ready & ~redirect;
  assign push = ~redirect & (~full | pop);
`ifdef FETCHQ_BYPASS_EN
  logic byp;
  assign byp = ~filled & ~redirect;
  // a bypassed instruction taken by decode advances fetch without occupying a slot
  assign wr = push & ~(byp & dec_ready);
  always_comb begin
    dec_valid = filled | byp;
    dec_inst = filled ? inst_mem[head] : byp ? imem_data : last_inst;
    dec_pc = filled ? pc_mem[head] : byp ? fetch_pc : last_pc;
  end
`else
  assign wr = push;
  always_comb begin
    dec_valid = filled;
    dec_inst = filled ? inst_mem[head] : last_inst;
    dec_pc = filled ? pc_mem[head] : last_pc;
  end
`endif
  // last_* keep the decode outputs stable while the queue is empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      last_pc <= '0;
      last_inst <= '0;
    end else begin
      if (dec_valid) begin
        last_pc <= dec_pc;
        last_inst <= dec_inst;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc;
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (push) fetch_pc <= fetch_pc + AW'(1);
        if (wr) tail <= tail + PW'(1);
        if (pop) head <= head + PW'(1);
        count <= count + CW'(wr) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      pc_mem[tail] <= fetch_pc;
      inst_mem[tail] <= imem_data;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed plus randomized checks of fetch_queue against a queue-based model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, reset = 0, redirect = 0, dec_ready = 0;
  logic [7:0] redirect_pc = 0, imem_addr, dec_pc;
  logic [15:0] imem_data, dec_inst;
  logic dec_valid;
  logic [2:0] count;
  logic [15:0] mem [256];
  int n_cmp = 0, n_err = 0;
  logic [7:0] fpc;
  logic [23:0] q[$];
  logic [23:0] last;
  assign imem_data = mem[imem_addr];
  always #5 clk = ~clk;
  fetch_queue #(.DEPTH(DEPTH), .AW(8), .IW(16)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_data(imem_data), .dec_valid(dec_valid),
    .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc), .count(count)
  );
  task automatic chk(input string n, input int a, input int e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic model_reset();
    q.delete();
    fpc = 0;
    last = 0;
  endtask
  task automatic model_step();
    logic v;
    logic [23:0] shown;
    v = q.size() != 0;
    shown = v ? q[0] : last;
`ifdef FETCHQ_BYPASS_EN
    if (!v && !redirect) begin
      v = 1;
      shown = {fpc, mem[fpc]};
    end
`endif
    chk("imem_addr", imem_addr, fpc);
    chk("count", count, q.size());
    chk("dec_valid", dec_valid, v);
    chk("dec_inst", dec_inst, shown[15:0]);
    chk("dec_pc", dec_pc, shown[23:16]);
    if (v) last = shown;
    if (redirect) begin
      q.delete();
      fpc = redirect_pc;
    end else if (v && dec_ready && q.size() == 0) begin
      fpc++;
    end else begin
      if (v && dec_ready) void'(q.pop_front());
      if (q.size() < DEPTH) begin
        q.push_back({fpc, mem[fpc]});
        fpc++;
      end
    end
  endtask
  task automatic step(input logic r, input logic [7:0] rpc, input logic rdy);
    redirect = r;
    redirect_pc = rpc;
    dec_ready = rdy;
    #1;
    model_step();
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int pcs[6];
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
    repeat (4) step(0, 0, 0);
    chk("fill_count", count, 4);
    chk("fill_addr", imem_addr, 4);
    chk("fill_inst", dec_inst, 16'h1000);
    chk("fill_pc", dec_pc, 0);
    step(0, 0, 0);
    chk("full_hold_addr", imem_addr, 4);
    for (int i = 0; i < 6; i++) begin
      chk("stream_pc", dec_pc, i);
      chk("stream_count", count, 4);
      step(0, 0, 1);
    end
    step(1, 8'd253, 0);
    n = 0;
    for (int i = 0; i < 6; i++) pcs[i] = -1;
    for (int i = 0; i < 12 && n < 6; i++) begin
      if (dec_valid) begin
        pcs[n] = dec_pc;
        n++;
      end
      step(0, 0, 1);
    end
    chk("wrap0", pcs[0], 253);
    chk("wrap1", pcs[1], 254);
    chk("wrap2", pcs[2], 255);
    chk("wrap3", pcs[3], 0);
    chk("wrap4", pcs[4], 1);
    chk("wrap5", pcs[5], 2);
    step(1, 8'd10, 0);
    repeat (4) step(0, 0, 0);
    chk("redir_head", dec_pc, 10);
    step(1, 8'h40, 1);
    chk("redir_count", count, 0);
    chk("redir_addr", imem_addr, 8'h40);
`ifndef FETCHQ_BYPASS_EN
    chk("redir_valid", dec_valid, 0);
`endif
    step(0, 0, 0);
    chk("redir_pc", dec_pc, 8'h40);
    step(1, 8'h20, 0);
    repeat (3) step(0, 0, 0);
    chk("pre_rst_count", count, 3);
    #2 reset = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_addr", imem_addr, 0);
`ifndef FETCHQ_BYPASS_EN
    chk("rst_valid", dec_valid, 0);
    chk("rst_inst", dec_inst, 0);
    chk("rst_pc", dec_pc, 0);
`endif
    model_reset();
    @(negedge clk);
    reset = 1;
`ifdef FETCHQ_BYPASS_EN
    mem[7] = 16'hA5C3;
    step(1, 8'd7, 0);
    redirect = 0;
    dec_ready = 1;
    #1;
    chk("byp_valid", dec_valid, 1);
    chk("byp_inst", dec_inst, 16'hA5C3);
    chk("byp_pc", dec_pc, 7);
    step(0, 0, 1);
    chk("byp_addr", imem_addr, 8);
    chk("byp_count", count, 0);
`endif
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 9) < 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
